// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// Width codes, FSM encoding and wait-counter width live here.
package dmem_pkg;

  localparam int CNT_W = 3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Unsigned widths only make sense for loads.
  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/replication and load extract/extend.
// Misaligned low offset bits are masked here (H: bit 0, W: bits 1:0).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] wshift,
  output logic [31:0] rdata
);

  logic        is_b;
  logic        is_h;
  logic        sx;
  logic [1:0]  ofs;
  logic [31:0] sh;

  assign is_b = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_h = (funct3 == F3_H) || (funct3 == F3_HU);
  assign sx   = !funct3[2];

  always_comb begin
    ofs    = '0;
    be     = 4'b1111;
    wshift = wdata;
    unique case (1'b1)
      is_b: begin
        ofs    = off;
        be     = 4'b0001 << off;
        wshift = {4{wdata[7:0]}};
      end
      is_h: begin
        ofs    = {off[1], 1'b0};
        be     = 4'b0011 << {off[1], 1'b0};
        wshift = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sh    = word >> {ofs, 3'b000};
    rdata = sh;
    unique case (1'b1)
      is_b:    rdata = {{24{sx & sh[7]}}, sh[7:0]};
      is_h:    rdata = {{16{sx & sh[15]}}, sh[15:0]};
      default: rdata = sh;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data memory with fixed latency and valid/ready ports.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned H/W accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic           q_we;
  logic [31:0]    q_addr;
  logic [31:0]    q_wdata;
  logic [2:0]     q_f3;

  logic [31:0]    mem [DEPTH_WORDS];

  logic           idle;
  logic           c_we;
  logic [31:0]    c_addr;
  logic [31:0]    c_wdata;
  logic [2:0]     c_f3;
  logic [IDX_W-1:0] idx;
  logic           oob;
  logic           mis;
  logic           err;
  logic           access;
  logic           wr;
  logic [3:0]     be;
  logic [31:0]    wshift;
  logic [31:0]    ld;
  logic [31:0]    rd_out;

  assign idle      = (state == S_IDLE);
  assign req_ready = idle;

  // Zero-wait accesses use the live request on the accept cycle.
  assign c_we    = idle ? req_we     : q_we;
  assign c_addr  = idle ? req_addr   : q_addr;
  assign c_wdata = idle ? req_wdata  : q_wdata;
  assign c_f3    = idle ? req_funct3 : q_f3;

  assign idx = c_addr[IDX_W+1:2];
  assign oob = |c_addr[31:IDX_W+2];

`ifdef DMEM_MISALIGN_ERR_EN
  assign mis = ((c_f3[1:0] == 2'b01) && c_addr[0]) ||
               ((c_f3[1:0] == 2'b10) && (c_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign err = !f3_legal(c_we, c_f3) || oob || mis;

  assign access = (idle && req_valid && (WAIT_CYCLES == 0)) ||
                  ((state == S_WAIT) && (cnt == '0));
  assign wr     = access && c_we && !err && rst;
  assign rd_out = (err || c_we) ? '0 : ld;

  dmem_lane_align u_align (
    .funct3 (c_f3),
    .off    (c_addr[1:0]),
    .wdata  (c_wdata),
    .word   (mem[idx]),
    .be     (be),
    .wshift (wshift),
    .rdata  (ld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      q_we      <= 1'b0;
      q_addr    <= '0;
      q_wdata   <= '0;
      q_f3      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          q_we    <= req_we;
          q_addr  <= req_addr;
          q_wdata <= req_wdata;
          q_f3    <= req_funct3;
          if (WAIT_CYCLES == 0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= rd_out;
          end else begin
            state <= S_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        S_WAIT: if (cnt == '0) begin
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= rd_out;
        end else begin
          cnt <= cnt - 1'b1;
        end
        S_RESP: if (rsp_ready) begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (WAIT_CYCLES=1, DEPTH_WORDS=256).
// Expected responses are queued at accept and popped at rsp_valid.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic        we,
                     input logic [31:0] addr,
                     input logic [31:0] wdata,
                     input logic [2:0]  f3,
                     input logic [31:0] exp_d,
                     input logic        exp_e,
                     input int          hold);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    check("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    sb.push_back('{d: exp_d, e: exp_e});
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check("latency", 32'(n), 32'd2);
    e = sb.pop_front();
    check("rdata", rsp_rdata, e.d);
    check("err", 32'(rsp_err), 32'(e.e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_rdata", rsp_rdata, e.d);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(req_ready), 32'd1);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 0);
    txn(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 0);
    txn(1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 1'b0, 0);
    txn(1'b0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 1'b0, 0);
    txn(1'b0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 1'b0, 0);
    txn(1'b0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 1'b0, 0);
    txn(1'b1, 32'h11, 32'h55, 3'b000, 32'h0, 1'b0, 0);
    txn(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 0);
`ifdef DMEM_MISALIGN_ERR_EN
    txn(1'b0, 32'h12, 32'h0, 3'b010, 32'h0, 1'b1, 0);
`else
    txn(1'b0, 32'h12, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 0);
`endif
    txn(1'b1, 32'h400, 32'h11111111, 3'b010, 32'h0, 1'b1, 0);
    txn(1'b0, 32'h400, 32'h0, 3'b010, 32'h0, 1'b1, 0);
    txn(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 0);
    txn(1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1, 0);
    txn(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 0);
    txn(1'b1, 32'h16, 32'h1234ABCD, 3'b001, 32'h0, 1'b0, 0);
    txn(1'b0, 32'h16, 32'h0, 3'b001, 32'hFFFFABCD, 1'b0, 0);
    txn(1'b0, 32'h16, 32'h0, 3'b101, 32'h0000ABCD, 1'b0, 0);

    // back-pressure: response must sit still for five cycles
    txn(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 5);
    @(negedge clk);
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);

    // reset lands while a store is waiting
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h10;
    req_wdata  = 32'h12345678;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("wait_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_post", 32'(rsp_valid), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, 0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..7, meaning the added access latency in cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port req_funct3, input, 3 bits: RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-011 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-012 SHALL have port rsp_ready, input, 1 bit: the initiator consumes the response.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: load result, extended per funct3; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1 bit: the access was rejected.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE; one transaction outstanding at most.
REQ-016 SHALL capture we/addr/wdata/funct3 in IDLE when req_valid&req_ready, then go to WAIT loading counter WAIT_CYCLES-1, or go directly to ACCESS-in-RESP-entry when WAIT_CYCLES=0.
REQ-017 SHALL decrement the counter each WAIT cycle and, on the cycle the counter is 0, perform the access and enter RESP next edge; latency from accept edge to rsp_valid is WAIT_CYCLES+1 cycles.
REQ-018 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then return to IDLE; a new request is accepted no earlier than the cycle after the handshake.
REQ-019 SHALL on stores update only the addressed byte lanes (B: 1 lane, H: 2 lanes, W: 4 lanes) using the low bits of req_wdata.
REQ-020 SHALL on loads sign-extend for funct3 000/001, zero-extend for 100/101, and pass the full word for 010.
REQ-021 SHALL index storage with addr[log2(DEPTH_WORDS)+1:2]; an address with any bit set above that range SHALL give rsp_err=1.
REQ-022 SHALL treat funct3 011, 110 and 111 (and 100/101 on stores) as illegal, giving rsp_err=1.
REQ-023 SHALL on any error perform no storage write and return rsp_rdata=0.
REQ-024 SHALL ignore req_valid outside IDLE, and SHALL ignore rsp_ready outside RESP.

Reset
REQ-025 SHALL on rst=0 immediately force state IDLE, counter 0, rsp_valid=0, rsp_err=0, rsp_rdata=0; after release req_ready=1.
REQ-026 SHALL abort an in-flight transaction on reset mid-operation, with no write if reset asserts before the access cycle; storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 SHALL with macro DMEM_MISALIGN_ERR_EN defined flag a misaligned access (H with addr[0]=1, W with addr[1:0]!=0) as rsp_err=1 with no write.
REQ-028 SHALL without DMEM_MISALIGN_ERR_EN silently clear the misaligned low address bits (H: addr[0], W: addr[1:0]) and complete the access normally.

Structure
REQ-029 SHALL place funct3 width constants, the FSM state encoding and the counter width constant in shared package dmem_pkg.
REQ-030 SHALL place store lane-enable/shift and load extract/extend logic in a combinational sub-module dmem_lane_align.

Verification
REQ-031 SHALL verify: WAIT_CYCLES=1, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_valid exactly 2 cycles after each accept.
REQ-032 SHALL verify: after the previous test, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-033 SHALL verify: SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF.
REQ-034 SHALL verify: with the macro defined, LW 0x12 -> rsp_err=1, rdata 0; without it, LW 0x12 -> 0xDEAD55EF; SW to 0x400 (DEPTH 256) -> rsp_err=1 with storage unchanged.
REQ-035 SHALL verify: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; rst pulsed low during WAIT of an SW -> IDLE immediately and the target word unchanged.
